// File: rtl/midi_parser_if.sv
// Byte stream into the MIDI parser and the decoded events coming back out.
// Valid/ready: there is no ready; the parser accepts every byte on any cycle i_valid is high.
interface midi_parser_if;
    logic       i_valid;
    logic [7:0] i_data;
    logic [3:0] i_channel;
    logic       o_note_on;
    logic       o_note_off;
    logic       o_cc;
    logic       o_pb;
    logic       o_clock;
    logic [3:0] o_channel;
    logic [6:0] o_data1;
    logic [6:0] o_data2;
    logic [1:0] dbg_state;
    logic       dbg_running;

    modport slave (
        input  i_valid, i_data, i_channel,
        output o_note_on, o_note_off, o_cc, o_pb, o_clock,
        output o_channel, o_data1, o_data2, dbg_state, dbg_running
    );

    modport master (
        output i_valid, i_data, i_channel,
        input  o_note_on, o_note_off, o_cc, o_pb, o_clock,
        input  o_channel, o_data1, o_data2, dbg_state, dbg_running
    );
endinterface

// File: rtl/midi_parser.sv
// MIDI byte-stream parser: running status, real-time interleaving, SysEx skipping,
// and note/CC/pitch-bend event decode with an optional single-channel filter.
module midi_parser #(
    parameter bit OMNI = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    midi_parser_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

    state_t     state, state_n;
    logic [2:0] msg_type, msg_type_n;
    logic [3:0] msg_chan, msg_chan_n;
    logic       chan_ok, chan_ok_n;
    logic       running, running_n;
    logic [6:0] d1, d1_n;
    logic       note_on_n, note_off_n, cc_n, pb_n, clock_n;
    logic [3:0] channel_n;
    logic [6:0] data1_n, data2_n;
    logic       two_data;

    // Program change (0xC) and channel pressure (0xD) carry one data byte.
    assign two_data = (msg_type != 3'd4) && (msg_type != 3'd5);

    always_comb begin
        state_n    = state;
        msg_type_n = msg_type;
        msg_chan_n = msg_chan;
        chan_ok_n  = chan_ok;
        running_n  = running;
        d1_n       = d1;
        note_on_n  = 1'b0;
        note_off_n = 1'b0;
        cc_n       = 1'b0;
        pb_n       = 1'b0;
        clock_n    = 1'b0;
        channel_n  = bus.o_channel;
        data1_n    = bus.o_data1;
        data2_n    = bus.o_data2;
        if (bus.i_valid) begin
            if (bus.i_data >= 8'hF8) begin
                clock_n = (bus.i_data == 8'hF8);
            end else if (bus.i_data == 8'hF0) begin
                running_n = 1'b0;
                state_n   = SYSEX;
            end else if (bus.i_data >= 8'hF1) begin
                running_n = 1'b0;
                state_n   = IDLE;
            end else if (bus.i_data[7]) begin
                msg_type_n = bus.i_data[6:4];
                msg_chan_n = bus.i_data[3:0];
                chan_ok_n  = OMNI || (bus.i_data[3:0] == bus.i_channel);
                running_n  = 1'b1;
                state_n    = WAIT_D1;
            end else begin
                case (state)
                    WAIT_D1: begin
                        if (two_data) begin
                            d1_n    = bus.i_data[6:0];
                            state_n = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        state_n = WAIT_D1;
                        if (chan_ok) begin
                            case (msg_type)
                                3'd0: note_off_n = 1'b1;
                                3'd1: begin
                                    if (bus.i_data[6:0] != 7'd0) note_on_n  = 1'b1;
                                    else                         note_off_n = 1'b1;
                                end
                                3'd3: cc_n = 1'b1;
                                3'd6: pb_n = 1'b1;
                                default: ;
                            endcase
                        end
                        if (note_on_n || note_off_n || cc_n || pb_n) begin
                            channel_n = msg_chan;
                            data1_n   = d1;
                            data2_n   = bus.i_data[6:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= IDLE;
            msg_type       <= 3'd0;
            msg_chan       <= 4'd0;
            chan_ok        <= 1'b0;
            running        <= 1'b0;
            d1             <= 7'd0;
            bus.o_note_on  <= 1'b0;
            bus.o_note_off <= 1'b0;
            bus.o_cc       <= 1'b0;
            bus.o_pb       <= 1'b0;
            bus.o_clock    <= 1'b0;
            bus.o_channel  <= 4'd0;
            bus.o_data1    <= 7'd0;
            bus.o_data2    <= 7'd0;
        end else begin
            state          <= state_n;
            msg_type       <= msg_type_n;
            msg_chan       <= msg_chan_n;
            chan_ok        <= chan_ok_n;
            running        <= running_n;
            d1             <= d1_n;
            bus.o_note_on  <= note_on_n;
            bus.o_note_off <= note_off_n;
            bus.o_cc       <= cc_n;
            bus.o_pb       <= pb_n;
            bus.o_clock    <= clock_n;
            bus.o_channel  <= channel_n;
            bus.o_data1    <= data1_n;
            bus.o_data2    <= data2_n;
        end
    end

    assign bus.dbg_state   = state;
    assign bus.dbg_running = running;
endmodule

// File: tb/tb_midi_parser.sv
// Bench for midi_parser: one OMNI=0 and one OMNI=1 instance fed the same byte stream,
// compared every cycle against a message-level reference model.
module tb_midi_parser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    midi_parser_if bus0();
    midi_parser_if bus1();

    midi_parser #(.OMNI(1'b0)) dut0 (.i_clk(clk), .i_reset_n(rst_n), .bus(bus0.slave));
    midi_parser #(.OMNI(1'b1)) dut1 (.i_clk(clk), .i_reset_n(rst_n), .bus(bus1.slave));

    int checks = 0;
    int failures = 0;

    // Observed/expected vector: {note_on, note_off, cc, pb, clock, channel[3:0], data1[6:0], data2[6:0]}
    logic [22:0] exp_q0[$];
    logic [22:0] exp_q1[$];
    logic [22:0] obs_q0[$];
    logic [22:0] obs_q1[$];
    logic [7:0]  stim_q[$];
    logic [3:0]  ich = 4'd0;

    // Reference model: running status plus a list of collected data bytes.
    bit          m_rs;
    logic [3:0]  m_type;
    logic [3:0]  m_chan;
    bit          m_match [2];
    logic [6:0]  m_args[$];
    logic [3:0]  h_ch [2];
    logic [6:0]  h_d1 [2];
    logic [6:0]  h_d2 [2];

    function automatic logic [22:0] vec0();
        return {bus0.o_note_on, bus0.o_note_off, bus0.o_cc, bus0.o_pb, bus0.o_clock,
                bus0.o_channel, bus0.o_data1, bus0.o_data2};
    endfunction

    function automatic logic [22:0] vec1();
        return {bus1.o_note_on, bus1.o_note_off, bus1.o_cc, bus1.o_pb, bus1.o_clock,
                bus1.o_channel, bus1.o_data1, bus1.o_data2};
    endfunction

    task automatic model_reset();
        m_rs = 1'b0;
        m_args.delete();
        for (int k = 0; k < 2; k++) begin
            h_ch[k] = 4'd0;
            h_d1[k] = 7'd0;
            h_d2[k] = 7'd0;
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        logic [4:0] st [2];
        st[0] = 5'b0;
        st[1] = 5'b0;
        if (v) begin
            if (b >= 8'hF8) begin
                if (b == 8'hF8) begin
                    st[0] = 5'b00001;
                    st[1] = 5'b00001;
                end
            end else if (b >= 8'hF0) begin
                m_rs = 1'b0;
                m_args.delete();
            end else if (b[7]) begin
                m_rs = 1'b1;
                m_type = b[7:4];
                m_chan = b[3:0];
                m_match[0] = (b[3:0] == ich);
                m_match[1] = 1'b1;
                m_args.delete();
            end else if (m_rs) begin
                m_args.push_back(b[6:0]);
                if (m_type == 4'hC || m_type == 4'hD) begin
                    m_args.delete();
                end else if (m_args.size() == 2) begin
                    for (int k = 0; k < 2; k++) begin
                        if (m_match[k] && m_type != 4'hA) begin
                            case (m_type)
                                4'h9:    st[k] = (m_args[1] != 7'd0) ? 5'b10000 : 5'b01000;
                                4'h8:    st[k] = 5'b01000;
                                4'hB:    st[k] = 5'b00100;
                                default: st[k] = 5'b00010;
                            endcase
                            h_ch[k] = m_chan;
                            h_d1[k] = m_args[0];
                            h_d2[k] = m_args[1];
                        end
                    end
                    m_args.delete();
                end
            end
        end
        exp_q0.push_back({st[0], h_ch[0], h_d1[0], h_d2[0]});
        exp_q1.push_back({st[1], h_ch[1], h_d1[1], h_d2[1]});
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs captured.
    task automatic drive_cycle(input bit v, input logic [7:0] b);
        model_step(v, b);
        bus0.i_valid = v;  bus0.i_data = b;  bus0.i_channel = ich;
        bus1.i_valid = v;  bus1.i_data = b;  bus1.i_channel = ich;
        @(posedge clk);
        @(negedge clk);
        obs_q0.push_back(vec0());
        obs_q1.push_back(vec1());
        bus0.i_valid = 1'b0;
        bus1.i_valid = 1'b0;
    endtask

    task automatic play(input int gap_max);
        logic [7:0] b;
        while (stim_q.size() != 0) begin
            b = stim_q.pop_front();
            drive_cycle(1'b1, b);
            repeat ($urandom_range(0, gap_max)) drive_cycle(1'b0, 8'h00);
        end
        drive_cycle(1'b0, 8'h00);
    endtask

    // Outputs are sampled while reset is still low to see the asynchronous clear.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        model_step(1'b0, 8'h00);
        obs_q0.push_back(vec0());
        obs_q1.push_back(vec1());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_byte();
        logic [6:0] r;
        r = 7'($urandom);
        case ($urandom_range(0, 10))
            0, 1, 2: return {1'b1, 3'($urandom_range(0, 6)), 4'($urandom_range(0, 3))};
            3:       return 8'h00;
            4, 5, 6: return {1'b0, r};
            7:       return 8'hF8;
            8:       return 8'hF0 + 8'($urandom_range(0, 7));
            9:       return 8'hF9 + 8'($urandom_range(0, 6));
            default: return {1'b0, r};
        endcase
    endfunction

    task automatic test_reset();
        logic [22:0] e, o;
        do_reset();
        stim_q = '{8'h3C};
        play(0);
        while (exp_q0.size() != 0) begin
            e = exp_q0.pop_front(); o = obs_q0.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL reset omni0 got=%h exp=%h", o, e); end
        end
        while (exp_q1.size() != 0) begin
            e = exp_q1.pop_front(); o = obs_q1.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL reset omni1 got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_note_on();
        logic [22:0] e, o;
        ich = 4'd0;
        stim_q = '{8'h90, 8'h3C, 8'h64};
        play(0);
        while (exp_q0.size() != 0) begin
            e = exp_q0.pop_front(); o = obs_q0.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL note_on omni0 got=%h exp=%h", o, e); end
        end
        while (exp_q1.size() != 0) begin
            e = exp_q1.pop_front(); o = obs_q1.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL note_on omni1 got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_running_status();
        logic [22:0] e, o;
        stim_q = '{8'h40, 8'h00, 8'h41, 8'h22};
        play(1);
        while (exp_q0.size() != 0) begin
            e = exp_q0.pop_front(); o = obs_q0.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL running_status omni0 got=%h exp=%h", o, e); end
        end
        while (exp_q1.size() != 0) begin
            e = exp_q1.pop_front(); o = obs_q1.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL running_status omni1 got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_realtime();
        logic [22:0] e, o;
        stim_q = '{8'hB0, 8'h07, 8'hF8, 8'h7F, 8'hFE, 8'hC0, 8'h05, 8'h06};
        play(0);
        while (exp_q0.size() != 0) begin
            e = exp_q0.pop_front(); o = obs_q0.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL realtime omni0 got=%h exp=%h", o, e); end
        end
        while (exp_q1.size() != 0) begin
            e = exp_q1.pop_front(); o = obs_q1.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL realtime omni1 got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_channel_filter();
        logic [22:0] e, o;
        ich = 4'd0;
        stim_q = '{8'h91, 8'h3C, 8'h64, 8'hA0, 8'h10, 8'h20};
        play(0);
        while (exp_q0.size() != 0) begin
            e = exp_q0.pop_front(); o = obs_q0.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL channel_filter omni0 got=%h exp=%h", o, e); end
        end
        while (exp_q1.size() != 0) begin
            e = exp_q1.pop_front(); o = obs_q1.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL channel_filter omni1 got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_sysex();
        logic [22:0] e, o;
        ich = 4'd0;
        stim_q = '{8'hF0, 8'h43, 8'h12, 8'hF7, 8'h3C, 8'h64, 8'hE0, 8'h00, 8'h40,
                   8'hF0, 8'h11, 8'h95, 8'h30, 8'h31, 8'hF3, 8'h30, 8'h31};
        play(0);
        while (exp_q0.size() != 0) begin
            e = exp_q0.pop_front(); o = obs_q0.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL sysex omni0 got=%h exp=%h", o, e); end
        end
        while (exp_q1.size() != 0) begin
            e = exp_q1.pop_front(); o = obs_q1.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL sysex omni1 got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [22:0] e, o;
        ich = 4'd0;
        stim_q = '{8'h90, 8'h3C};
        play(0);
        do_reset();
        stim_q = '{8'h64};
        play(0);
        while (exp_q0.size() != 0) begin
            e = exp_q0.pop_front(); o = obs_q0.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL reset_mid omni0 got=%h exp=%h", o, e); end
        end
        while (exp_q1.size() != 0) begin
            e = exp_q1.pop_front(); o = obs_q1.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL reset_mid omni1 got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [22:0] e, o;
        ich = 4'd1;
        repeat (250) stim_q.push_back(rand_byte());
        play(0);
        while (exp_q0.size() != 0) begin
            e = exp_q0.pop_front(); o = obs_q0.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL back_to_back omni0 got=%h exp=%h", o, e); end
        end
        while (exp_q1.size() != 0) begin
            e = exp_q1.pop_front(); o = obs_q1.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL back_to_back omni1 got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_random();
        logic [22:0] e, o;
        repeat (25) begin
            ich = 4'($urandom_range(0, 3));
            repeat (16) stim_q.push_back(rand_byte());
            play(2);
        end
        while (exp_q0.size() != 0) begin
            e = exp_q0.pop_front(); o = obs_q0.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL random omni0 got=%h exp=%h", o, e); end
        end
        while (exp_q1.size() != 0) begin
            e = exp_q1.pop_front(); o = obs_q1.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL random omni1 got=%h exp=%h", o, e); end
        end
    endtask

    initial begin
        bus0.i_valid = 1'b0;  bus0.i_data = 8'h00;  bus0.i_channel = 4'd0;
        bus1.i_valid = 1'b0;  bus1.i_data = 8'h00;  bus1.i_channel = 4'd0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_note_on();
        test_running_status();
        test_realtime();
        test_channel_filter();
        test_sysex();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/midi_parser.md
MIDI_PARSER -- requirements
Module: midi_parser

Interface
REQ-001 Parameter OMNI, default 0; when 1, accept channel messages on all 16 channels, otherwise only on i_channel.
REQ-002 i_clk  input  1  system clock, 48 MHz, same domain as the MIDI RX UART.
REQ-003 i_reset_n  input  1  reset, asynchronous and active-low.
REQ-004 i_valid  input  1  one-cycle strobe; i_data holds a received byte (UART o_ready).
REQ-005 i_data  input  8  received MIDI byte.
REQ-006 i_channel  input  4  receive channel 0-15, used when OMNI=0, sampled with each status byte.
REQ-007 o_note_on  output  1  one-cycle strobe: note-on event.
REQ-008 o_note_off  output  1  one-cycle strobe: note-off event.
REQ-009 o_cc  output  1  one-cycle strobe: control-change event.
REQ-010 o_pb  output  1  one-cycle strobe: pitch-bend event.
REQ-011 o_channel  output  4  channel of the last event.
REQ-012 o_data1  output  7  note number, CC number, or pitch-bend LSB of the last event.
REQ-013 o_data2  output  7  velocity, CC value, or pitch-bend MSB of the last event.
REQ-014 o_clock  output  1  one-cycle strobe on 0xF8 timing clock.

Function
REQ-015 Byte class: bit7=1 is status; 0xF8-0xFF is real-time; 0xF0-0xF7 is system common; bit7=0 is data.
REQ-016 State machine: IDLE (no running status), WAIT_D1, WAIT_D2, SYSEX.
REQ-017 Channel status 0x80-0xEF from any state: latch type=i_data[6:4] and channel=i_data[3:0], set the running-status valid flag, go to WAIT_D1, discard any partial message.
REQ-018 Data byte in WAIT_D1, type 0x8/0x9/0xA/0xB/0xE: latch it as d1 and go to WAIT_D2.
REQ-019 Data byte in WAIT_D1, type 0xC/0xD (one data byte): consume it, emit no event, stay in WAIT_D1.
REQ-020 Data byte in WAIT_D2: form the message from d1 and this byte, emit its event per REQ-021, return to WAIT_D1 (running status).
REQ-021 Event mapping: 0x9 with d2!=0 gives o_note_on; 0x8, or 0x9 with d2=0, gives o_note_off with o_data2=d2; 0xB gives o_cc; 0xE gives o_pb; 0xA gives no event.
REQ-022 Latency: the event strobe and the updated o_channel/o_data1/o_data2 appear on the clock edge after the i_valid cycle of the final data byte.
REQ-023 Each strobe is exactly 1 cycle wide; at most one event strobe is high per cycle.
REQ-024 o_channel/o_data1/o_data2 change only with an event strobe and hold until the next event.
REQ-025 Channel filter: with OMNI=0 and channel!=i_channel, parse fully but suppress strobes and keep outputs unchanged.
REQ-026 Data byte in IDLE: ignore it, stay in IDLE.
REQ-027 Real-time byte in any state: state, d1 and running status unchanged; 0xF8 pulses o_clock on the next edge, other real-time bytes are ignored.
REQ-028 0xF0: clear running status, enter SYSEX; data bytes in SYSEX are discarded.
REQ-029 0xF7 or 0xF1-0xF6, from any state: clear running status, go to IDLE.
REQ-030 Channel status during SYSEX: terminate SYSEX and act per REQ-017.
REQ-031 i_valid low: no state change; only bytes with i_valid high are interpreted.
REQ-032 Data byte input is back-to-back capable: i_valid may be high on consecutive cycles, with every byte processed.

Reset
REQ-033 With i_reset_n low, asynchronously force: state IDLE, running status cleared, d1=0, all strobes 0, o_channel=0, o_data1=0, o_data2=0.
REQ-034 Reset mid-message discards the partial message; the first data byte after reset is ignored until a status byte arrives.

Verification
REQ-035 OMNI=0, i_channel=0; bytes 0x90,0x3C,0x64 -> one o_note_on, o_channel=0, o_data1=0x3C, o_data2=0x64, one cycle after the third i_valid.
REQ-036 Running status: 0x90,0x3C,0x64,0x40,0x00 -> o_note_on (0x3C,0x64), then o_note_off with o_data1=0x40, o_data2=0x00.
REQ-037 0xB0,0x07,0xF8,0x7F -> o_clock after 0xF8, then o_cc with o_data1=0x07, o_data2=0x7F; the real-time byte does not break the message.
REQ-038 OMNI=0, i_channel=0; 0x91,0x3C,0x64 -> no strobes, outputs unchanged; repeat with OMNI=1 -> o_note_on, o_channel=1.
REQ-039 0xF0,0x43,0x12,0xF7,0x3C,0x64 -> no events; 0xE0,0x00,0x40 -> o_pb, o_data1=0x00, o_data2=0x40.
REQ-040 0x90,0x3C then assert i_reset_n low then high; send 0x64 -> no event, outputs all zero.
